rs_param: RTL and testbench

Parametrised out-of-order reservation station sitting between rename/dispatch and the execute units. It accepts up to `DISPATCH_W` renamed instructions per cycle and captures source-operand readiness. It snoops up to `WAKE_W` completion broadcasts and issues up to `ISSUE_W` ready instructions per cycle in oldest-first order, gated per port by functional-unit availability. It adds a flush, dispatch backpressure and age-ordered selection.

---
 rtl/rs_param_pkg.sv | 30 +++
 rtl/rs_oldest_select.sv | 29 ++
 rtl/rs_param.sv | 202 ++++++++++++++++++++
 tb/tb_rs_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_param_pkg.sv
// Shared types for the reservation station: physical register tag,
// dispatched row payload, resident entry and default geometry.
package rs_param_pkg;

  localparam int unsigned RS_N_ENTRIES  = 8;
  localparam int unsigned RS_DISPATCH_W = 2;
  localparam int unsigned RS_ISSUE_W    = 3;
  localparam int unsigned RS_WAKE_W     = 2;
  localparam int unsigned PREG_W        = 6;
  localparam int unsigned OP_W          = 4;

  typedef logic [PREG_W-1:0] p_reg;

  typedef struct packed {
    logic [OP_W-1:0] op;
    p_reg            dst;
    p_reg            src1;
    logic            src1_rdy;
    p_reg            src2;
    logic            src2_rdy;
  } rs_row_struct;

  typedef struct packed {
    logic         valid;
    logic         src1_rdy;
    logic         src2_rdy;
    rs_row_struct row;
  } rs_entry_struct;

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest row among ready rows not already excluded.
// age[i][j]=1 means row i is older than row j.
module rs_oldest_select #(
  parameter int unsigned N_ENTRIES = 8
) (
  input  logic [N_ENTRIES-1:0]                ready,
  input  logic [N_ENTRIES-1:0][N_ENTRIES-1:0] age,
  input  logic [N_ENTRIES-1:0]                excl,
  output logic [N_ENTRIES-1:0]                grant,
  output logic                                found
);

  logic [N_ENTRIES-1:0] cand;
  logic [N_ENTRIES-1:0] self_bit;

  // A candidate wins when no other candidate is older than it
  always_comb begin
    cand     = ready & ~excl;
    found    = |cand;
    grant    = '0;
    self_bit = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      self_bit    = '0;
      self_bit[i] = 1'b1;
      grant[i]    = cand[i] & ~|(cand & ~age[i] & ~self_bit);
    end
  end

endmodule

// File: rtl/rs_param.sv
// Out-of-order reservation station: multi-port dispatch, wakeup snoop,
// age-ordered multi-port issue gated by functional-unit availability.
module rs_param
  import rs_param_pkg::*;
#(
  parameter int unsigned N_ENTRIES  = RS_N_ENTRIES,
  parameter int unsigned DISPATCH_W = RS_DISPATCH_W,
  parameter int unsigned ISSUE_W    = RS_ISSUE_W,
  parameter int unsigned WAKE_W     = RS_WAKE_W
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flush,
  input  logic [DISPATCH_W-1:0]               i_disp_valid,
  input  rs_row_struct [DISPATCH_W-1:0]       i_disp_rows,
  output logic                                o_disp_ready,
  input  logic [WAKE_W-1:0]                   i_wake_valid,
  input  p_reg [WAKE_W-1:0]                   i_wake_preg,
  input  logic [ISSUE_W-1:0]                  i_fu_ready,
  output logic [ISSUE_W-1:0]                  o_issue_valid,
  output rs_row_struct [ISSUE_W-1:0]          o_issue_rows,
  output logic [$clog2(N_ENTRIES+1)-1:0]      o_free_cnt
);

  localparam int unsigned CW = $clog2(N_ENTRIES + 1);

  rs_entry_struct [N_ENTRIES-1:0]         ent_q, ent_d;
  logic [N_ENTRIES-1:0][N_ENTRIES-1:0]    age_q, age_d;
  logic [N_ENTRIES-1:0]                   vld, rdy, issued;
  logic [ISSUE_W-1:0][N_ENTRIES-1:0]      take;
  logic [DISPATCH_W-1:0][N_ENTRIES-1:0]   alloc;
  logic [DISPATCH_W-1:0]                  disp_en;

  // Row validity and issue readiness from registered state
  always_comb begin
    vld = '0;
    rdy = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      vld[i] = ent_q[i].valid;
      rdy[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
    end
  end

  // Free-row count and dispatch acceptance, both from registered state
  always_comb begin
    o_free_cnt = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++)
      o_free_cnt = o_free_cnt + CW'(!ent_q[i].valid);
    o_disp_ready = (o_free_cnt >= CW'(DISPATCH_W));
  end

  // Select chain: a port whose unit is busy passes its candidate on,
  // so only enabled ports add their grant to the exclusion mask.
  for (genvar p = 0; p < ISSUE_W; p++) begin : g_sel
    logic [N_ENTRIES-1:0] excl;
    logic [N_ENTRIES-1:0] grant;
    logic                 found;
    rs_row_struct         row;

    if (p == 0) begin : g_first
      // First port sees every ready row
      always_comb excl = '0;
    end else begin : g_next
      // Later ports skip rows already taken by enabled lower ports
      always_comb excl = g_sel[p-1].excl |
                         (i_fu_ready[p-1] ? g_sel[p-1].grant : '0);
    end

    rs_oldest_select #(.N_ENTRIES(N_ENTRIES)) u_sel (
      .ready (rdy),
      .age   (age_q),
      .excl  (excl),
      .grant (grant),
      .found (found)
    );

    // Payload mux for the granted row
    always_comb begin
      row = '0;
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        if (grant[i]) begin
          row          = ent_q[i].row;
          row.src1_rdy = ent_q[i].src1_rdy;
          row.src2_rdy = ent_q[i].src2_rdy;
        end
      end
    end

    assign o_issue_valid[p] = found & i_fu_ready[p];
    assign o_issue_rows[p]  = row;
    assign take[p]          = i_fu_ready[p] ? grant : '0;
  end

  // Rows leaving this cycle
  always_comb begin
    issued = '0;
    for (int unsigned p = 0; p < ISSUE_W; p++)
      issued = issued | take[p];
  end

  // Allocation: each enabled port takes the lowest row that was free at
  // the start of the cycle and not claimed by a lower port
  always_comb begin
    logic [N_ENTRIES-1:0] claimed;
    logic                 got;
    claimed = vld;
    alloc   = '0;
    disp_en = '0;
    got     = 1'b0;
    for (int unsigned d = 0; d < DISPATCH_W; d++) begin
      disp_en[d] = i_disp_valid[d] & o_disp_ready & ~i_flush;
      got        = 1'b0;
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        if (disp_en[d] && !got && !claimed[i]) begin
          alloc[d][i] = 1'b1;
          claimed[i]  = 1'b1;
          got         = 1'b1;
        end
      end
    end
  end

  // Next state: wakeup, free issued rows, insert dispatched rows, flush.
  // A new row is younger than every surviving row and than rows placed by
  // lower dispatch ports, and older than rows placed by higher ports.
  always_comb begin
    logic [N_ENTRIES-1:0] keep;
    logic [N_ENTRIES-1:0] earlier;
    logic [N_ENTRIES-1:0] later;
    logic                 hit1, hit2;
    ent_d   = ent_q;
    age_d   = age_q;
    keep    = vld & ~issued;
    earlier = '0;
    later   = '0;
    hit1    = 1'b0;
    hit2    = 1'b0;

    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (ent_q[i].valid) begin
        for (int unsigned w = 0; w < WAKE_W; w++) begin
          if (i_wake_valid[w] && i_wake_preg[w] == ent_q[i].row.src1)
            ent_d[i].src1_rdy = 1'b1;
          if (i_wake_valid[w] && i_wake_preg[w] == ent_q[i].row.src2)
            ent_d[i].src2_rdy = 1'b1;
        end
      end
      if (issued[i]) begin
        ent_d[i].valid = 1'b0;
        age_d[i]       = '0;
        for (int unsigned j = 0; j < N_ENTRIES; j++)
          age_d[j][i] = 1'b0;
      end
    end

    for (int unsigned d = 0; d < DISPATCH_W; d++) begin
      if (disp_en[d]) begin
        later = '0;
        for (int unsigned e = d + 1; e < DISPATCH_W; e++)
          later = later | alloc[e];
        hit1 = i_disp_rows[d].src1_rdy;
        hit2 = i_disp_rows[d].src2_rdy;
        for (int unsigned w = 0; w < WAKE_W; w++) begin
          if (i_wake_valid[w] && i_wake_preg[w] == i_disp_rows[d].src1) hit1 = 1'b1;
          if (i_wake_valid[w] && i_wake_preg[w] == i_disp_rows[d].src2) hit2 = 1'b1;
        end
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
          if (alloc[d][i]) begin
            ent_d[i].valid        = 1'b1;
            ent_d[i].row          = i_disp_rows[d];
            ent_d[i].row.src1_rdy = hit1;
            ent_d[i].row.src2_rdy = hit2;
            ent_d[i].src1_rdy     = hit1;
            ent_d[i].src2_rdy     = hit2;
            age_d[i]              = later;
            for (int unsigned j = 0; j < N_ENTRIES; j++)
              age_d[j][i] = keep[j] | earlier[j];
          end
        end
        earlier = earlier | alloc[d];
      end
    end

    if (i_flush) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++)
        ent_d[i].valid = 1'b0;
      age_d = '0;
    end
  end

  // Station state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ent_q <= '0;
      age_q <= '0;
    end else begin
      ent_q <= ent_d;
      age_q <= age_d;
    end
  end

endmodule

// File: tb/tb_rs_param.sv
// Randomised and directed checks of rs_param against an age-ordered queue
// model of the station contents.
module tb_rs_param;
  import rs_param_pkg::*;

  localparam int N  = 8;
  localparam int D  = 2;
  localparam int I  = 3;
  localparam int W  = 2;
  localparam int CW = $clog2(N + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush;
  logic [D-1:0]         disp_valid;
  rs_row_struct [D-1:0] disp_rows;
  logic                 disp_ready;
  logic [W-1:0]         wake_valid;
  p_reg [W-1:0]         wake_preg;
  logic [I-1:0]         fu_ready;
  logic [I-1:0]         issue_valid;
  rs_row_struct [I-1:0] issue_rows;
  logic [CW-1:0]        free_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    rs_row_struct row;
    bit           r1;
    bit           r2;
  } mdl_t;

  mdl_t q[$];

  rs_param #(
    .N_ENTRIES  (N),
    .DISPATCH_W (D),
    .ISSUE_W    (I),
    .WAKE_W     (W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_disp_valid (disp_valid),
    .i_disp_rows  (disp_rows),
    .o_disp_ready (disp_ready),
    .i_wake_valid (wake_valid),
    .i_wake_preg  (wake_preg),
    .i_fu_ready   (fu_ready),
    .o_issue_valid(issue_valid),
    .o_issue_rows (issue_rows),
    .o_free_cnt   (free_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rs_row_struct mk(int op, int dst, int s1, bit r1, int s2, bit r2);
    rs_row_struct r;
    r.op       = OP_W'(op);
    r.dst      = PREG_W'(dst);
    r.src1     = PREG_W'(s1);
    r.src1_rdy = r1;
    r.src2     = PREG_W'(s2);
    r.src2_rdy = r2;
    return r;
  endfunction

  function automatic bit woken(p_reg r);
    bit h = 1'b0;
    for (int w = 0; w < W; w++)
      if (wake_valid[w] && wake_preg[w] == r) h = 1'b1;
    return h;
  endfunction

  task automatic idle();
    flush      = 1'b0;
    disp_valid = '0;
    disp_rows  = '0;
    wake_valid = '0;
    wake_preg  = '0;
    fu_ready   = '1;
  endtask

  // One cycle: compare outputs with the model, then advance the model
  // across the coming edge. Called with inputs already driven at negedge.
  task automatic step();
    bit           ev [I];
    rs_row_struct er [I];
    bit           taken[$];
    mdl_t         nq[$];
    mdl_t         e;
    int           k;
    bit           dr;
    #1;
    taken = {};
    foreach (q[i]) taken.push_back(1'b0);
    k = 0;
    for (int p = 0; p < I; p++) begin
      ev[p] = 1'b0;
      er[p] = '0;
      if (fu_ready[p]) begin
        while (k < q.size() && !(q[k].r1 && q[k].r2)) k++;
        if (k < q.size()) begin
          ev[p]          = 1'b1;
          er[p]          = q[k].row;
          er[p].src1_rdy = 1'b1;
          er[p].src2_rdy = 1'b1;
          taken[k]       = 1'b1;
          k++;
        end
      end
    end
    dr = (N - q.size()) >= D;
    chk("free_cnt", 64'(free_cnt), 64'(N - q.size()));
    chk("disp_ready", 64'(disp_ready), 64'(dr));
    for (int p = 0; p < I; p++) begin
      chk($sformatf("issue_valid%0d", p), 64'(issue_valid[p]), 64'(ev[p]));
      if (ev[p])
        chk($sformatf("issue_row%0d", p), 64'(issue_rows[p]), 64'(er[p]));
    end
    if (flush) begin
      q.delete();
    end else begin
      nq = {};
      foreach (q[i]) begin
        if (!taken[i]) begin
          e = q[i];
          if (woken(e.row.src1)) e.r1 = 1'b1;
          if (woken(e.row.src2)) e.r2 = 1'b1;
          nq.push_back(e);
        end
      end
      if (dr) begin
        for (int d = 0; d < D; d++) begin
          if (disp_valid[d]) begin
            e.row = disp_rows[d];
            e.r1  = disp_rows[d].src1_rdy | woken(disp_rows[d].src1);
            e.r2  = disp_rows[d].src2_rdy | woken(disp_rows[d].src2);
            nq.push_back(e);
          end
        end
      end
      q = nq;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    @(negedge clk);
    #1;
    chk("rst_free", 64'(free_cnt), 64'(N));
    chk("rst_ready", 64'(disp_ready), 64'(1));
    chk("rst_issue", 64'(issue_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Two ready rows issue next cycle on ports 0 and 1 in dispatch order
    idle();
    disp_valid = 2'b11;
    disp_rows[0] = mk(1, 10, 1, 1, 2, 1);
    disp_rows[1] = mk(2, 11, 3, 1, 4, 1);
    step();
    idle(); step(); step();

    // Wakeup after dispatch, then wakeup bypass in the dispatch cycle
    disp_valid = 2'b01;
    disp_rows[0] = mk(3, 12, 5, 0, 6, 1);
    step();
    idle(); step();
    wake_valid = 2'b01; wake_preg[0] = PREG_W'(5);
    step();
    idle(); step(); step();
    disp_valid = 2'b01;
    disp_rows[0] = mk(4, 13, 5, 0, 6, 1);
    wake_valid = 2'b10; wake_preg[1] = PREG_W'(5);
    step();
    idle(); step(); step();

    // Fill with rows waiting on p9, overflow is dropped, then drain
    for (int c = 0; c < 6; c++) begin
      idle();
      disp_valid = 2'b11;
      disp_rows[0] = mk(c, 20 + 2 * c, 9, 0, 1, 1);
      disp_rows[1] = mk(c + 8, 21 + 2 * c, 2, 1, 9, 0);
      step();
    end
    idle();
    wake_valid = 2'b01; wake_preg[0] = PREG_W'(9);
    step();
    idle();
    repeat (4) step();

    // Only port 1 enabled: it carries the oldest, the other row waits
    idle();
    disp_valid = 2'b11;
    disp_rows[0] = mk(5, 30, 1, 1, 1, 1);
    disp_rows[1] = mk(6, 31, 1, 1, 1, 1);
    step();
    idle(); fu_ready = 3'b010; step();
    fu_ready = 3'b010; step();
    idle(); step();

    // Flush with five resident rows and a concurrent dispatch
    for (int c = 0; c < 3; c++) begin
      idle();
      disp_valid = (c == 2) ? 2'b01 : 2'b11;
      disp_rows[0] = mk(7, 40 + c, 20, 0, 1, 1);
      disp_rows[1] = mk(8, 50 + c, 20, 0, 1, 1);
      step();
    end
    idle();
    flush = 1'b1;
    disp_valid = 2'b11;
    disp_rows[0] = mk(9, 60, 1, 1, 1, 1);
    disp_rows[1] = mk(9, 61, 1, 1, 1, 1);
    wake_valid = 2'b01; wake_preg[0] = PREG_W'(20);
    step();
    idle(); step();

    // Asynchronous reset mid-cycle with rows resident
    idle();
    disp_valid = 2'b11;
    disp_rows[0] = mk(10, 62, 1, 1, 1, 1);
    disp_rows[1] = mk(11, 63, 1, 1, 1, 1);
    step();
    idle(); fu_ready = '0; step();
    fu_ready = '1;
    #1;
    chk("pre_rst_issue", 64'(issue_valid), 64'(3'b011));
    chk("pre_rst_free", 64'(free_cnt), 64'(N - 2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_issue", 64'(issue_valid), 64'(0));
    chk("async_rst_free", 64'(free_cnt), 64'(N));
    chk("async_rst_ready", 64'(disp_ready), 64'(1));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      flush      = ($urandom_range(0, 31) == 0);
      disp_valid = D'($urandom);
      for (int d = 0; d < D; d++)
        disp_rows[d] = mk($urandom_range(0, 15), $urandom_range(0, 63),
                          $urandom_range(0, 15), 1'($urandom),
                          $urandom_range(0, 15), 1'($urandom));
      wake_valid = W'($urandom);
      for (int w = 0; w < W; w++)
        wake_preg[w] = PREG_W'($urandom_range(0, 15));
      fu_ready = I'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
